// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: registered multi-port lookup, tree-PLRU
// replacement, entry kill, and a one-set-per-cycle invalidate sweep on reset/flush.
module btb_assoc #(
    parameter int NUM_SETS    = 16,
    parameter int WAYS        = 2,
    parameter int TAG_LEN     = 6,
    parameter int FETCH_PORTS = 2,
    parameter int TYPE_W      = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          ready,
    input  logic                          flush,
    input  logic [FETCH_PORTS-1:0]        fetch_valid,
    input  logic [32*FETCH_PORTS-1:0]     fetch_pc,
    output logic [FETCH_PORTS-1:0]        hit,
    output logic [32*FETCH_PORTS-1:0]     target_pc,
    output logic [TYPE_W*FETCH_PORTS-1:0] ins_type,
    input  logic                          upd_valid,
    input  logic                          upd_kill,
    input  logic [31:0]                   upd_pc,
    input  logic [31:0]                   upd_target,
    input  logic [TYPE_W-1:0]             upd_ins_type
);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int LOG_W  = $clog2(WAYS);
    localparam int WAY_W  = (WAYS > 1) ? LOG_W : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    function automatic logic [TAG_LEN-1:0] fold_tag(input logic [29:0] pc_hi);
        logic [TAG_LEN-1:0] t;
        t = '0;
        for (int i = 0; i < 30; i++) t[i % TAG_LEN] ^= pc_hi[i];
        return t;
    endfunction

    // Tree nodes are heap-ordered; a node bit of 1 points the victim search right.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] t;
        int node;
        t    = bits;
        node = 0;
        for (int l = 0; l < LOG_W; l++) begin
            t[node] = ~way[LOG_W-1-l];
            node    = 2 * node + 1 + int'(way[LOG_W-1-l]);
        end
        return t;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        logic [WAY_W-1:0] w;
        int node;
        w    = '0;
        node = 0;
        for (int l = 0; l < LOG_W; l++) begin
            w[LOG_W-1-l] = bits[node];
            node         = 2 * node + 1 + int'(bits[node]);
        end
        return w;
    endfunction

    function automatic logic [WAY_W-1:0] first_set(input logic [WAYS-1:0] v);
        logic [WAY_W-1:0] w;
        w = '0;
        for (int i = WAYS - 1; i >= 0; i--) if (v[i]) w = WAY_W'(i);
        return w;
    endfunction

    logic [0:0]         state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [WAYS-1:0]    valid_q [NUM_SETS];
    logic [PLRU_W-1:0]  plru_q  [NUM_SETS];
    logic [PLRU_W-1:0]  plru_d  [NUM_SETS];
    logic [TAG_LEN-1:0] tag_mem [NUM_SETS][WAYS];
    logic [31:0]        tgt_mem [NUM_SETS][WAYS];
    logic [TYPE_W-1:0]  typ_mem [NUM_SETS][WAYS];
    logic               run;

    logic [FETCH_PORTS-1:0]        hit_q;
    logic [32*FETCH_PORTS-1:0]     target_q;
    logic [TYPE_W*FETCH_PORTS-1:0] type_q;

    assign run       = (state_q == S_RUN);
    assign ready     = run;
    assign hit       = hit_q;
    assign target_pc = target_q;
    assign ins_type  = type_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = S_INIT;
            cnt_d   = '0;
        end else if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(NUM_SETS - 1)) state_d = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [IDX_W-1:0]       f_set  [FETCH_PORTS];
    logic [TAG_LEN-1:0]     f_tag  [FETCH_PORTS];
    logic [WAYS-1:0]        f_hitv [FETCH_PORTS];
    logic [WAY_W-1:0]       f_way  [FETCH_PORTS];
    logic [FETCH_PORTS-1:0] f_hit;

    always_comb begin
        for (int p = 0; p < FETCH_PORTS; p++) begin
            f_set[p] = fetch_pc[32*p+2 +: IDX_W];
            f_tag[p] = fold_tag(fetch_pc[32*p+2 +: 30]);
            for (int w = 0; w < WAYS; w++)
                f_hitv[p][w] = valid_q[f_set[p]][w] && (tag_mem[f_set[p]][w] == f_tag[p]);
            f_way[p] = first_set(f_hitv[p]);
            f_hit[p] = fetch_valid[p] && run && (|f_hitv[p]);
        end
    end

    logic [IDX_W-1:0]   u_set;
    logic [TAG_LEN-1:0] u_tag;
    logic [WAYS-1:0]    u_hitv;
    logic [WAY_W-1:0]   u_way;
    logic               u_write, u_kill;

    assign u_set = upd_pc[2 +: IDX_W];
    assign u_tag = fold_tag(upd_pc[31:2]);

    // Way choice: existing entry, then lowest free way, then PLRU victim.
    always_comb begin
        for (int w = 0; w < WAYS; w++)
            u_hitv[w] = valid_q[u_set][w] && (tag_mem[u_set][w] == u_tag);
        if (|u_hitv)
            u_way = first_set(u_hitv);
        else if (~&valid_q[u_set])
            u_way = first_set(~valid_q[u_set]);
        else
            u_way = plru_victim(plru_q[u_set]);
        u_write = upd_valid && !upd_kill && run;
        u_kill  = upd_valid && upd_kill && run && (|u_hitv);
    end

    // Lookup touches go in port order; the update touch is applied last so it wins.
    always_comb begin
        plru_d = plru_q;
        for (int p = 0; p < FETCH_PORTS; p++)
            if (f_hit[p]) plru_d[f_set[p]] = plru_touch(plru_d[f_set[p]], f_way[p]);
        if (u_write) plru_d[u_set] = plru_touch(plru_d[u_set], u_way);
    end

    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            valid_q[cnt_q] <= '0;
            plru_q[cnt_q]  <= '0;
        end else begin
            plru_q <= plru_d;
            if (u_write)
                valid_q[u_set][u_way] <= 1'b1;
            else if (u_kill)
                valid_q[u_set][u_way] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (u_write) begin
            tag_mem[u_set][u_way] <= u_tag;
            tgt_mem[u_set][u_way] <= upd_target;
            typ_mem[u_set][u_way] <= upd_ins_type;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q    <= '0;
            target_q <= '0;
            type_q   <= '0;
        end else begin
            for (int p = 0; p < FETCH_PORTS; p++) begin
                hit_q[p]                   <= f_hit[p];
                target_q[32*p +: 32]       <= f_hit[p] ? tgt_mem[f_set[p]][f_way[p]] : '0;
                type_q[TYPE_W*p +: TYPE_W] <= f_hit[p] ? typ_mem[f_set[p]][f_way[p]] : '0;
            end
        end
    end

    // PC bits [1:0] never participate in indexing or tagging.
    logic unused_pc_bits;
    always_comb begin
        unused_pc_bits = ^upd_pc[1:0];
        for (int p = 0; p < FETCH_PORTS; p++) unused_pc_bits = unused_pc_bits ^ (^fetch_pc[32*p +: 2]);
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc: expected lookup results are queued when a fetch is
// driven and popped one cycle later when the registered outputs appear.
module tb_btb_assoc;
    localparam int NUM_SETS = 16;
    localparam int WAYS     = 2;
    localparam int TAG_LEN  = 6;
    localparam int FP       = 2;
    localparam int TYPE_W   = 3;

    localparam logic [31:0] PC_A = 32'h1c000010;
    localparam logic [31:0] PC_B = 32'h1c000050;
    localparam logic [31:0] PC_C = 32'h1c000090;
    localparam logic [31:0] PC_D = 32'h1c0000d0;
    localparam logic [31:0] PC_E = 32'h1c000020;
    localparam logic [31:0] PC_F = 32'h1c000030;

    logic                 clk = 1'b0;
    logic                 reset, flush, upd_valid, upd_kill, ready;
    logic [FP-1:0]        fetch_valid, hit;
    logic [32*FP-1:0]     fetch_pc, target_pc;
    logic [TYPE_W*FP-1:0] ins_type;
    logic [31:0]          upd_pc, upd_target;
    logic [TYPE_W-1:0]    upd_ins_type;

    typedef struct packed {
        logic [FP-1:0]        hit;
        logic [32*FP-1:0]     tgt;
        logic [TYPE_W*FP-1:0] typ;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    btb_assoc #(
        .NUM_SETS(NUM_SETS), .WAYS(WAYS), .TAG_LEN(TAG_LEN),
        .FETCH_PORTS(FP), .TYPE_W(TYPE_W)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .hit(hit), .target_pc(target_pc), .ins_type(ins_type),
        .upd_valid(upd_valid), .upd_kill(upd_kill), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_ins_type(upd_ins_type)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_valid = '0;
        upd_valid   = 1'b0;
        upd_kill    = 1'b0;
        flush       = 1'b0;
    endtask

    function automatic exp_t mk(input logic [1:0] h, input logic [31:0] t1, input logic [31:0] t0,
                                input logic [2:0] y1, input logic [2:0] y0);
        return exp_t'({h, t1, t0, y1, y0});
    endfunction

    task automatic drive_fetch(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                               input exp_t e);
        fetch_valid = v;
        fetch_pc    = {pc1, pc0};
        sb.push_back(e);
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] typ,
                             input logic kill);
        upd_valid    = 1'b1;
        upd_kill     = kill;
        upd_pc       = pc;
        upd_target   = tgt;
        upd_ins_type = typ;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        idle();
        fetch_pc = '0; upd_pc = '0; upd_target = '0; upd_ins_type = '0;
        step(); step();
        checks++;
        if ({ready, hit, target_pc, ins_type} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b hit=%b tgt=%h typ=%b, expected all zero",
                     ready, hit, target_pc, ins_type);
        end
        reset = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            checks++;
            if (ready !== (i == 16)) begin
                errors++;
                $display("FAIL reset_ready[%0d]: got %b expected %b", i, ready, (i == 16));
            end
            if (i > 0) begin
                e = sb.pop_front(); checks++;
                if ({hit, target_pc, ins_type} !== e) begin
                    errors++;
                    $display("FAIL sweep_lookup[%0d]: got hit=%b tgt=%h, expected hit=%b tgt=%h", i, hit, target_pc, e.hit, e.tgt);
                end
            end
            if (i < 16) begin
                drive_fetch(2'b11, PC_A, PC_B, '0);
                step();
            end else idle();
        end
    endtask

    task automatic test_basic();
        exp_t e;
        drive_upd(PC_A, 32'h1c000100, 3'b010, 1'b0); step(); idle();
        drive_fetch(2'b11, PC_A, 32'h1c000014, mk(2'b01, 32'h0, 32'h1c000100, 3'b000, 3'b010));
        step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL basic_two_port: got hit=%b tgt=%h typ=%b, expected hit=%b tgt=%h typ=%b", hit, target_pc, ins_type, e.hit, e.tgt, e.typ);
        end
        drive_fetch(2'b10, 32'h1c000014, PC_A, mk(2'b10, 32'h1c000100, 32'h0, 3'b010, 3'b000));
        step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL basic_port1: got hit=%b tgt=%h typ=%b, expected hit=%b tgt=%h typ=%b", hit, target_pc, ins_type, e.hit, e.tgt, e.typ);
        end
    endtask

    task automatic test_replace();
        exp_t e;
        drive_upd(PC_A, 32'h1c0000a0, 3'b001, 1'b0); step(); idle();
        drive_upd(PC_B, 32'h1c0000b0, 3'b011, 1'b0); step(); idle();
        drive_fetch(2'b01, PC_A, 32'h0, mk(2'b01, 32'h0, 32'h1c0000a0, 3'b000, 3'b001));
        step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL replace_fetch_a: got hit=%b tgt=%h typ=%b, expected hit=%b tgt=%h typ=%b", hit, target_pc, ins_type, e.hit, e.tgt, e.typ);
        end
        drive_upd(PC_C, 32'h1c0000c0, 3'b101, 1'b0); step(); idle();
        drive_fetch(2'b11, PC_A, PC_B, mk(2'b01, 32'h0, 32'h1c0000a0, 3'b000, 3'b001));
        step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL replace_a_b: got hit=%b tgt=%h typ=%b, expected hit=%b tgt=%h typ=%b", hit, target_pc, ins_type, e.hit, e.tgt, e.typ);
        end
        drive_fetch(2'b01, PC_C, 32'h0, mk(2'b01, 32'h0, 32'h1c0000c0, 3'b000, 3'b101));
        step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL replace_c: got hit=%b tgt=%h typ=%b, expected hit=%b tgt=%h typ=%b", hit, target_pc, ins_type, e.hit, e.tgt, e.typ);
        end
    endtask

    task automatic test_kill();
        exp_t e;
        drive_upd(PC_A, 32'h0, 3'b000, 1'b1); step(); idle();
        drive_fetch(2'b01, PC_A, 32'h0, '0); step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL kill_a: got hit=%b tgt=%h, expected hit=%b tgt=%h", hit, target_pc, e.hit, e.tgt);
        end
        drive_upd(PC_D, 32'h1c000300, 3'b100, 1'b0); step(); idle();
        drive_fetch(2'b11, PC_D, PC_B, mk(2'b01, 32'h0, 32'h1c000300, 3'b000, 3'b100));
        step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL kill_d_b: got hit=%b tgt=%h typ=%b, expected hit=%b tgt=%h typ=%b", hit, target_pc, ins_type, e.hit, e.tgt, e.typ);
        end
        drive_fetch(2'b01, PC_C, 32'h0, mk(2'b01, 32'h0, 32'h1c0000c0, 3'b000, 3'b101));
        step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL kill_c_kept: got hit=%b tgt=%h typ=%b, expected hit=%b tgt=%h typ=%b", hit, target_pc, ins_type, e.hit, e.tgt, e.typ);
        end
        drive_upd(PC_B, 32'h0, 3'b000, 1'b1); step(); idle();
        drive_fetch(2'b11, PC_C, PC_D, mk(2'b11, 32'h1c000300, 32'h1c0000c0, 3'b100, 3'b101));
        step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL kill_miss_no_effect: got hit=%b tgt=%h typ=%b, expected hit=%b tgt=%h typ=%b", hit, target_pc, ins_type, e.hit, e.tgt, e.typ);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        drive_upd(PC_E, 32'h1c000500, 3'b111, 1'b0); step(); idle();
        drive_fetch(2'b01, PC_E, 32'h0, mk(2'b01, 32'h0, 32'h1c000500, 3'b000, 3'b111));
        step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL flush_pre_e: got hit=%b tgt=%h typ=%b, expected hit=%b tgt=%h typ=%b", hit, target_pc, ins_type, e.hit, e.tgt, e.typ);
        end
        flush = 1'b1; step(); flush = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            checks++;
            if (ready !== (i == 16)) begin
                errors++;
                $display("FAIL flush_ready[%0d]: got %b expected %b", i, ready, (i == 16));
            end
            if (i == 13) drive_upd(PC_F, 32'h1c000600, 3'b001, 1'b0);
            else upd_valid = 1'b0;
            if (i < 16) step();
        end
        idle();
        drive_fetch(2'b11, PC_C, PC_D, '0); step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL flush_c_d: got hit=%b tgt=%h, expected hit=%b tgt=%h", hit, target_pc, e.hit, e.tgt);
        end
        drive_fetch(2'b11, PC_E, PC_F, '0); step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL flush_e_f: got hit=%b tgt=%h, expected hit=%b tgt=%h", hit, target_pc, e.hit, e.tgt);
        end
        flush = 1'b1; step(); flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL flush_first_sweep[%0d]: got %b expected 0", i, ready);
            end
            if (i < 7) step();
        end
        flush = 1'b1; step(); flush = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            checks++;
            if (ready !== (i == 16)) begin
                errors++;
                $display("FAIL flush_restart_ready[%0d]: got %b expected %b", i, ready, (i == 16));
            end
            if (i < 16) step();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive_upd(PC_E, 32'h1c000700, 3'b110, 1'b0);
        drive_fetch(2'b01, PC_E, 32'h0, '0);
        step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL same_cycle_miss: got hit=%b tgt=%h, expected hit=%b tgt=%h", hit, target_pc, e.hit, e.tgt);
        end
        drive_fetch(2'b01, PC_E, 32'h0, mk(2'b01, 32'h0, 32'h1c000700, 3'b000, 3'b110));
        step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL same_cycle_refetch: got hit=%b tgt=%h typ=%b, expected hit=%b tgt=%h typ=%b", hit, target_pc, ins_type, e.hit, e.tgt, e.typ);
        end
        drive_upd(PC_E, 32'h1c000800, 3'b011, 1'b0); step(); idle();
        drive_fetch(2'b10, 32'h0, PC_E, mk(2'b10, 32'h1c000800, 32'h0, 3'b011, 3'b000));
        step(); idle();
        e = sb.pop_front(); checks++;
        if ({hit, target_pc, ins_type} !== e) begin
            errors++;
            $display("FAIL overwrite_hit: got hit=%b tgt=%h typ=%b, expected hit=%b tgt=%h typ=%b", hit, target_pc, ins_type, e.hit, e.tgt, e.typ);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_replace();
        test_kill();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer for the fetch stage; successor to the 2-way, dual-port BTB.
- Adds configurable ways and fetch ports, tree-PLRU replacement, registered lookups, explicit entry kill, and a multi-cycle invalidate sweep on reset and on flush.
- Sits between the IF PC generator and the branch-resolve stage.

Parameters:
- NUM_SETS, 16, number of sets; power of 2, at least 2.
- WAYS, 2, associativity; power of 2, at least 1.
- TAG_LEN, 6, width of the folded tag.
- FETCH_PORTS, 2, number of parallel lookup ports.
- TYPE_W, 3, width of the instruction-type field.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ready  out  1  high when the array is usable (no sweep in progress)
- flush  in  1  invalidate all entries; starts a sweep
- fetch_valid  in  FETCH_PORTS  per-port lookup request
- fetch_pc  in  32*FETCH_PORTS  lookup PCs; port p uses bits [32p+31:32p]
- hit  out  FETCH_PORTS  registered per-port hit
- target_pc  out  32*FETCH_PORTS  registered predicted targets
- ins_type  out  TYPE_W*FETCH_PORTS  registered stored type
- upd_valid  in  1  update request from branch resolve
- upd_kill  in  1  qualifies upd_valid: remove the entry instead of writing it
- upd_pc  in  32  branch PC being updated
- upd_target  in  32  resolved target
- upd_ins_type  in  TYPE_W  resolved type

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Indexing:
  - set = pc[2+log2(NUM_SETS)-1 : 2].
  - tag = XOR of pc[31:2] split into consecutive TAG_LEN-bit chunks starting at bit 2; the last chunk is zero-extended.
- Storage per entry: valid, tag, target, type. Per set: WAYS-1 PLRU bits (none when WAYS=1).
- Only valid bits and PLRU bits are reset or swept. Tag, target and type arrays are never reset.
- Sweep FSM, two states, INIT and RUN:
  - reset=1 forces INIT with the sweep counter at 0.
  - INIT: each cycle clears the valid and PLRU bits of set[counter] and increments counter; after set NUM_SETS-1, go to RUN.
  - ready = (state==RUN), registered. It goes high exactly NUM_SETS cycles after reset deasserts.
  - flush in RUN, or in INIT, goes to INIT with counter=0; a flush mid-sweep restarts the sweep.
  - While in INIT: fetch results are forced to hit=0 and updates are ignored.
- Lookup latency is 1 cycle:
  - The array is sampled at the edge where fetch_valid[p]=1; hit/target_pc/ins_type[p] are valid the following cycle.
  - hit[p]=0 if fetch_valid[p] was 0; target_pc and ins_type then hold 0.
- Reset values of all outputs: ready=0, hit=0, target_pc=0, ins_type=0.
- Hit detection: a way hits when valid && tag matches. If several ways hit, the lowest-numbered way is used.
- PLRU touch on lookup hits: applied in port order 0..FETCH_PORTS-1, then the update touch is applied last and wins. All touches commit at the same edge.
- Update, when upd_valid && !upd_kill in RUN:
  - If the tag hits in the set, overwrite that way.
  - Else write the lowest-numbered invalid way.
  - Else write the PLRU victim way.
  - Set valid, then touch PLRU toward the written way.
- Kill, when upd_valid && upd_kill in RUN: if the tag hits, clear that way's valid bit and do not touch PLRU. On a miss, no effect.
- Same-cycle update and lookup of the same entry: the lookup sees the pre-update contents (no bypass).
- WAYS=1: direct-mapped; the victim is always way 0.

Test Plan:
- Reset, then release → ready=0 for 16 cycles and 1 on the 17th; a fetch of any PC during the sweep returns hit=0.
- upd 0x1c000010 → 0x1c000100, type 3'b010; then fetch port0 0x1c000010 and port1 0x1c000014 → next cycle hit=2'b01, target_pc[31:0]=0x1c000100, ins_type[2:0]=3'b010.
- Set 4, WAYS=2: insert A=0x1c000010, insert B=0x1c000050, fetch A, insert C=0x1c000090 → C evicts B; fetch A/B/C → hit, miss, hit.
- Kill A after the previous scenario → A misses; insert D=0x1c0000d0 → fills the freed way; B stays absent and C still hits.
- Fill 3 entries, assert flush for 1 cycle → ready low for 16 cycles; all 3 PCs miss afterward. A flush in cycle 8 of the sweep restarts it (ready low for 16 more cycles).
- Update 0x1c000020 and fetch 0x1c000020 in the same cycle → miss next cycle; refetch → hit with the new target.
